// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-wide data memory port.
// Define SUBWORD_EN to enable byte/halfword access (read-modify-write stores, extended loads).
module mem_access_unit #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              DM_ena,
  output logic              DM_R,
  output logic              DM_W,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [31:0]       DM_wdata,
  input  logic [31:0]       DM_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rbuf;
  logic                w_accept;
  logic                w_illegal;
  logic [31:0]         w_store_word;
  logic [31:0]         w_load_word;

  assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef SUBWORD_EN
  logic [1:0]          r_size;
  logic                r_signed;
  logic [1:0]          r_boff;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic                w_unused;

  // Address bits above the word port never reach the memory.
  assign w_unused = ^req_addr[31:ADDR_W+2];

  always_comb begin
    case (req_size)
      2'd0:    w_illegal = 1'b0;
      2'd1:    w_illegal = req_addr[0];
      2'd2:    w_illegal = |req_addr[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_store_word = r_rbuf;
    case (r_size)
      2'd0:    w_store_word[{r_boff, 3'b000} +: 8]      = r_wdata[7:0];
      2'd1:    w_store_word[{r_boff[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_store_word = r_wdata;
    endcase
  end

  assign w_byte = r_rbuf[{r_boff, 3'b000} +: 8];
  assign w_half = r_rbuf[{r_boff[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'd0:    w_load_word = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_word = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_word = r_rbuf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_boff   <= 2'd0;
    end else if (w_accept) begin
      r_size   <= req_size;
      r_signed <= req_signed;
      r_boff   <= req_addr[1:0];
    end
  end
`else
  logic                w_unused;

  // Without sub-word support the sign flag and upper address bits are irrelevant.
  assign w_unused     = ^{req_signed, req_addr[31:ADDR_W+2]};
  assign w_illegal    = (req_size != 2'd2) || (|req_addr[1:0]);
  assign w_store_word = r_wdata;
  assign w_load_word  = r_rbuf;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_illegal)
            w_next = S_RESP;
          else if (req_we && (req_size == 2'd2))
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
`ifdef SUBWORD_EN
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
`else
      S_READ:  w_next = S_RESP;
`endif
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'h0;
      r_rbuf  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_err   <= w_illegal;
        r_waddr <= req_addr[ADDR_W+1:2];
        r_wdata <= req_wdata;
      end
      if (r_state == S_READ)
        r_rbuf <= DM_rdata;
    end
  end

  // Memory-side and response outputs decode only from registered state.
  always_comb begin
    // NOTE: every output is defaulted first so no path through the case infers a latch.
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    DM_ena     = 1'b0;
    DM_R       = 1'b0;
    DM_W       = 1'b0;
    DM_addr    = '0;
    DM_wdata   = 32'h0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        DM_ena  = 1'b1;
        DM_R    = 1'b1;
        DM_addr = r_waddr;
      end
      S_WRITE: begin
        DM_ena   = 1'b1;
        DM_W     = 1'b1;
        DM_addr  = r_waddr;
        DM_wdata = w_store_word;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_err || r_we) ? 32'h0 : w_load_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a simple word-wide memory model.
// Sub-word vectors are selected by SUBWORD_EN, matching the RTL build.
module tb_mem_access_unit;

  localparam int ADDR_W = 11;
`ifdef SUBWORD_EN
  localparam logic [31:0] W1_FINAL = 32'h1234AA5A;
`else
  localparam logic [31:0] W1_FINAL = 32'h8899AABB;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              DM_ena;
  logic              DM_R;
  logic              DM_W;
  logic [ADDR_W-1:0] DM_addr;
  logic [31:0]       DM_wdata;
  logic [31:0]       DM_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int n_total = 0;
  int n_bad   = 0;

  int          t_lat, t_wcnt, t_rcnt, t_ena, t_rcyc, t_wcyc;
  logic [31:0] t_rdata, t_waddr, t_wdata;
  logic        t_err, t_ready;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .DM_ena     (DM_ena),
    .DM_R       (DM_R),
    .DM_W       (DM_W),
    .DM_addr    (DM_addr),
    .DM_wdata   (DM_wdata),
    .DM_rdata   (DM_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read while DM_R, commit on the falling edge while DM_W.
  assign DM_rdata = DM_R ? mem[DM_addr] : 32'h0;
  always @(negedge clk) if (DM_ena && DM_W) mem[DM_addr] <= DM_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, hold req_valid until the response, and record what the port did.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    t_lat = 0; t_wcnt = 0; t_rcnt = 0; t_ena = 0; t_rcyc = 0; t_wcyc = 0;
    t_rdata = 32'h0; t_err = 1'b0; t_waddr = 32'h0; t_wdata = 32'h0; t_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (DM_ena) t_ena++;
      if (DM_R) begin t_rcnt++; t_rcyc = c; end
      if (DM_W) begin
        t_wcnt++; t_wcyc = c;
        t_waddr = 32'(DM_addr);
        t_wdata = DM_wdata;
      end
      if (resp_valid) begin
        t_lat = c; t_rdata = resp_rdata; t_err = resp_err; t_ready = req_ready;
        break;
      end
    end
    req_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic chk_load(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] exp);
    run_req(1'b0, size, sgn, addr, 32'h0);
    check({tag, "_lat"}, 32'(t_lat), 32'd2);
    check({tag, "_data"}, t_rdata, exp);
    check({tag, "_err"}, {31'h0, t_err}, 32'h0);
  endtask

  task automatic chk_err(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
    run_req(we, size, 1'b1, addr, 32'hCAFEF00D);
    check({tag, "_lat"}, 32'(t_lat), 32'd1);
    check({tag, "_err"}, {31'h0, t_err}, 32'h1);
    check({tag, "_data"}, t_rdata, 32'h0);
    check({tag, "_ena"}, 32'(t_ena), 32'd0);
  endtask

  initial begin
    int rv_seen;
    int dw_seen;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ctl", {26'h0, req_ready, resp_valid, resp_err, DM_ena, DM_R, DM_W}, 32'h20);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr", 32'(DM_addr), 32'h0);
    check("rst_wdata", DM_wdata, 32'h0);
    check("rst_rbuf", dut.r_rbuf, 32'h0);

    // Word store then load.
    run_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8899AABB);
    check("sw_lat", 32'(t_lat), 32'd2);
    check("sw_wcnt", 32'(t_wcnt), 32'd1);
    check("sw_rcnt", 32'(t_rcnt), 32'd0);
    check("sw_waddr", t_waddr, 32'h1);
    check("sw_wdata", t_wdata, 32'h8899AABB);
    check("sw_rdata", t_rdata, 32'h0);
    check("sw_ready_resp", {31'h0, t_ready}, 32'h0);
    check("sw_mem", mem[1], 32'h8899AABB);
    chk_load("lw4", 2'd2, 1'b0, 32'h4, 32'h8899AABB);

`ifdef SUBWORD_EN
    chk_load("lb5", 2'd0, 1'b1, 32'h5, 32'hFFFFFFAA);
    chk_load("lbu5", 2'd0, 1'b0, 32'h5, 32'h000000AA);
    chk_load("lh6", 2'd1, 1'b1, 32'h6, 32'hFFFF8899);

    run_req(1'b1, 2'd1, 1'b0, 32'h6, 32'hFFFF1234);
    check("sh_lat", 32'(t_lat), 32'd3);
    check("sh_rcyc", 32'(t_rcyc), 32'd1);
    check("sh_wcyc", 32'(t_wcyc), 32'd2);
    check("sh_wcnt", 32'(t_wcnt), 32'd1);
    check("sh_wdata", t_wdata, 32'h1234AABB);
    check("sh_rdata", t_rdata, 32'h0);

    run_req(1'b1, 2'd0, 1'b0, 32'h4, 32'h0000005A);
    check("sb_lat", 32'(t_lat), 32'd3);
    check("sb_wdata", t_wdata, 32'h1234AA5A);
    check("sb_mem", mem[1], 32'h1234AA5A);

    chk_load("lhu6", 2'd1, 1'b0, 32'h6, 32'h00001234);
    chk_load("lb7", 2'd0, 1'b1, 32'h7, 32'h00000012);
    chk_load("lh4", 2'd1, 1'b1, 32'h4, 32'hFFFFAA5A);
`else
    chk_err("lb5_off", 1'b0, 2'd0, 32'h5);
    chk_err("sh6_off", 1'b1, 2'd1, 32'h6);
    check("sh6_off_mem", mem[1], 32'h8899AABB);
`endif

    // Illegal and misaligned requests.
    chk_err("lh3", 1'b0, 2'd1, 32'h3);
    chk_err("lw6", 1'b0, 2'd2, 32'h6);
    chk_err("size3", 1'b0, 2'd3, 32'h0);
    chk_err("sw6", 1'b1, 2'd2, 32'h6);
    check("sw6_mem", mem[1], W1_FINAL);

    // Top word of the port.
    run_req(1'b1, 2'd2, 1'b0, 32'h1FFC, 32'hDEADBEEF);
    check("top_waddr", t_waddr, 32'h7FF);
    check("top_mem", mem[2047], 32'hDEADBEEF);
    chk_load("top_lw", 2'd2, 1'b0, 32'h1FFC, 32'hDEADBEEF);

    // Reset during the READ cycle drops the request without a write.
    @(negedge clk);
`ifdef SUBWORD_EN
    req_we = 1'b1; req_size = 2'd1; req_addr = 32'h6; req_wdata = 32'h00005555;
`else
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4; req_wdata = 32'h0;
`endif
    req_signed = 1'b0;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rr_in_read", {30'h0, DM_R, DM_W}, 32'h2);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rr_idle", {26'h0, req_ready, resp_valid, resp_err, DM_ena, DM_R, DM_W}, 32'h20);
    rv_seen = 0;
    dw_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
      if (DM_W) dw_seen++;
    end
    check("rr_no_resp", 32'(rv_seen), 32'd0);
    check("rr_no_write", 32'(dw_seen), 32'd0);
    check("rr_mem", mem[1], W1_FINAL);
    chk_load("rr_after", 2'd2, 1'b0, 32'h4, W1_FINAL);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
